aes_inv_sub_bytes: RTL and testbench

Sequential InvSubBytes engine for the AES decryption datapath. It accepts a 128-bit state over a valid/ready handshake, replaces every byte with its AES inverse S-box value (FIPS-197 Figure 14), and returns the result over a second valid/ready handshake. `LANES` inverse S-box lookups run per cycle, so area and latency can be traded against each other. It sits in the decryption round loop between InvShiftRows and AddRoundKey, and undoes the forward substitution used on the encryption side.

---
 rtl/aes_inv_sub_bytes.sv | 106 ++++++++++
 tb/tb_aes_inv_sub_bytes.sv | 277 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/aes_inv_sub_bytes.sv
// rtl/aes_inv_sub_bytes.sv - sequential AES InvSubBytes engine, LANES inverse S-box lookups per cycle
module aes_inv_sub_bytes #(
  parameter int LANES = 1
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [0:127] in_state,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [0:127] out_state,
  output logic         busy
);

  generate
    if (LANES != 1 && LANES != 2 && LANES != 4 && LANES != 8 && LANES != 16) begin : g_bad_lanes
      $error("aes_inv_sub_bytes: LANES must be 1, 2, 4, 8 or 16");
    end
  endgenerate

  localparam logic [3:0] LAST = 4'(16 / LANES - 1);

  localparam logic [7:0] INV_SBOX [256] = '{
    8'h52, 8'h09, 8'h6a, 8'hd5, 8'h30, 8'h36, 8'ha5, 8'h38, 8'hbf, 8'h40, 8'ha3, 8'h9e, 8'h81, 8'hf3, 8'hd7, 8'hfb,
    8'h7c, 8'he3, 8'h39, 8'h82, 8'h9b, 8'h2f, 8'hff, 8'h87, 8'h34, 8'h8e, 8'h43, 8'h44, 8'hc4, 8'hde, 8'he9, 8'hcb,
    8'h54, 8'h7b, 8'h94, 8'h32, 8'ha6, 8'hc2, 8'h23, 8'h3d, 8'hee, 8'h4c, 8'h95, 8'h0b, 8'h42, 8'hfa, 8'hc3, 8'h4e,
    8'h08, 8'h2e, 8'ha1, 8'h66, 8'h28, 8'hd9, 8'h24, 8'hb2, 8'h76, 8'h5b, 8'ha2, 8'h49, 8'h6d, 8'h8b, 8'hd1, 8'h25,
    8'h72, 8'hf8, 8'hf6, 8'h64, 8'h86, 8'h68, 8'h98, 8'h16, 8'hd4, 8'ha4, 8'h5c, 8'hcc, 8'h5d, 8'h65, 8'hb6, 8'h92,
    8'h6c, 8'h70, 8'h48, 8'h50, 8'hfd, 8'hed, 8'hb9, 8'hda, 8'h5e, 8'h15, 8'h46, 8'h57, 8'ha7, 8'h8d, 8'h9d, 8'h84,
    8'h90, 8'hd8, 8'hab, 8'h00, 8'h8c, 8'hbc, 8'hd3, 8'h0a, 8'hf7, 8'he4, 8'h58, 8'h05, 8'hb8, 8'hb3, 8'h45, 8'h06,
    8'hd0, 8'h2c, 8'h1e, 8'h8f, 8'hca, 8'h3f, 8'h0f, 8'h02, 8'hc1, 8'haf, 8'hbd, 8'h03, 8'h01, 8'h13, 8'h8a, 8'h6b,
    8'h3a, 8'h91, 8'h11, 8'h41, 8'h4f, 8'h67, 8'hdc, 8'hea, 8'h97, 8'hf2, 8'hcf, 8'hce, 8'hf0, 8'hb4, 8'he6, 8'h73,
    8'h96, 8'hac, 8'h74, 8'h22, 8'he7, 8'had, 8'h35, 8'h85, 8'he2, 8'hf9, 8'h37, 8'he8, 8'h1c, 8'h75, 8'hdf, 8'h6e,
    8'h47, 8'hf1, 8'h1a, 8'h71, 8'h1d, 8'h29, 8'hc5, 8'h89, 8'h6f, 8'hb7, 8'h62, 8'h0e, 8'haa, 8'h18, 8'hbe, 8'h1b,
    8'hfc, 8'h56, 8'h3e, 8'h4b, 8'hc6, 8'hd2, 8'h79, 8'h20, 8'h9a, 8'hdb, 8'hc0, 8'hfe, 8'h78, 8'hcd, 8'h5a, 8'hf4,
    8'h1f, 8'hdd, 8'ha8, 8'h33, 8'h88, 8'h07, 8'hc7, 8'h31, 8'hb1, 8'h12, 8'h10, 8'h59, 8'h27, 8'h80, 8'hec, 8'h5f,
    8'h60, 8'h51, 8'h7f, 8'ha9, 8'h19, 8'hb5, 8'h4a, 8'h0d, 8'h2d, 8'he5, 8'h7a, 8'h9f, 8'h93, 8'hc9, 8'h9c, 8'hef,
    8'ha0, 8'he0, 8'h3b, 8'h4d, 8'hae, 8'h2a, 8'hf5, 8'hb0, 8'hc8, 8'heb, 8'hbb, 8'h3c, 8'h83, 8'h53, 8'h99, 8'h61,
    8'h17, 8'h2b, 8'h04, 8'h7e, 8'hba, 8'h77, 8'hd6, 8'h26, 8'he1, 8'h69, 8'h14, 8'h63, 8'h55, 8'h21, 8'h0c, 8'h7d
  };

  typedef enum logic [1:0] {
    IDLE = 2'b00,
    BUSY = 2'b01,
    DONE = 2'b10
  } state_t;

  state_t           state, state_d;
  logic [0:15][7:0] st, st_sub;
  logic [3:0]       cnt;
  logic [3:0]       idx;

  always_comb begin
    state_d = IDLE;
    case (state)
      IDLE:    state_d = in_valid ? BUSY : IDLE;
      BUSY:    state_d = (cnt == LAST) ? DONE : BUSY;
      DONE:    state_d = out_ready ? IDLE : DONE;
      default: state_d = IDLE;
    endcase
  end

  // Byte group cnt gets its LANES lookups; every other byte passes through.
  always_comb begin
    st_sub = st;
    idx    = '0;
    for (int l = 0; l < LANES; l++) begin
      idx         = 4'(int'(cnt) * LANES + l);
      st_sub[idx] = INV_SBOX[st[idx]];
    end
  end

  // Handshake outputs are flops loaded from the next state, so nothing combinational reaches a port.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      st        <= '0;
      cnt       <= '0;
      in_ready  <= 1'b1;
      out_valid <= 1'b0;
      busy      <= 1'b0;
    end else begin
      state     <= state_d;
      in_ready  <= (state_d == IDLE);
      out_valid <= (state_d == DONE);
      busy      <= (state_d == BUSY) || (state_d == DONE);
      case (state)
        IDLE: begin
          if (in_valid) begin
            st  <= in_state;
            cnt <= '0;
          end
        end
        BUSY: begin
          st  <= st_sub;
          cnt <= (cnt == LAST) ? 4'd0 : cnt + 4'd1;
        end
        default: ;
      endcase
    end
  end

  assign out_state = st;

endmodule

// File: tb/tb_aes_inv_sub_bytes.sv
// tb/tb_aes_inv_sub_bytes.sv - self-checking bench for aes_inv_sub_bytes across all legal LANES
module tb_aes_inv_sub_bytes;

  logic         clk = 1'b0;
  logic         rst_n;
  logic [4:0]   in_valid, out_ready;
  logic [4:0]   in_ready, out_valid, busy;
  logic [0:127] in_state;
  logic [0:127] out_state [5];

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  for (genvar g = 0; g < 5; g++) begin : g_dut
    aes_inv_sub_bytes #(.LANES(1 << g)) u_dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .in_valid  (in_valid[g]),
      .in_ready  (in_ready[g]),
      .in_state  (in_state),
      .out_valid (out_valid[g]),
      .out_ready (out_ready[g]),
      .out_state (out_state[g]),
      .busy      (busy[g])
    );
  end

  // Reference tables derived from GF(2^8) arithmetic, not copied from any table.
  logic [7:0] ref_sbox [256];
  logic [7:0] ref_inv  [256];

  function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p, x;
    p = 8'h00;
    x = a;
    for (int i = 0; i < 8; i++) begin
      if (b[i]) p ^= x;
      x = {x[6:0], 1'b0} ^ (x[7] ? 8'h1b : 8'h00);
    end
    return p;
  endfunction

  function automatic logic [7:0] ginv(input logic [7:0] a);
    if (a == 8'h00) return 8'h00;
    for (int c = 1; c < 256; c++)
      if (gmul(a, 8'(c)) == 8'h01) return 8'(c);
    return 8'h00;
  endfunction

  task automatic build_tables();
    logic [7:0] b, s;
    for (int x = 0; x < 256; x++) begin
      b = ginv(8'(x));
      s = b ^ {b[6:0], b[7]} ^ {b[5:0], b[7:6]} ^ {b[4:0], b[7:5]} ^ {b[3:0], b[7:4]} ^ 8'h63;
      ref_sbox[x] = s;
      ref_inv[s]  = 8'(x);
    end
  endtask

  function automatic logic [127:0] inv_state(input logic [127:0] s);
    logic [127:0] r;
    for (int k = 0; k < 16; k++) r[8*k +: 8] = ref_inv[s[8*k +: 8]];
    return r;
  endfunction

  function automatic logic [127:0] fwd_state(input logic [127:0] s);
    logic [127:0] r;
    for (int k = 0; k < 16; k++) r[8*k +: 8] = ref_sbox[s[8*k +: 8]];
    return r;
  endfunction

  task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic check_bit(input string name, input logic act, input logic exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %b expected %b", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic run_block(input int i, input logic [127:0] d, output logic [127:0] got, output int lat);
    check_bit($sformatf("u%0d_ready_before_accept", i), in_ready[i], 1'b1);
    in_state     = d;
    in_valid[i]  = 1'b1;
    out_ready[i] = 1'b1;
    tick();
    in_valid[i] = 1'b0;
    lat = 0;
    while (!out_valid[i] && lat < 40) begin
      tick();
      lat++;
    end
    check_bit($sformatf("u%0d_out_valid_seen", i), out_valid[i], 1'b1);
    got = out_state[i];
    tick();
    check_bit($sformatf("u%0d_out_valid_one_cycle", i), out_valid[i], 1'b0);
    check_bit($sformatf("u%0d_ready_after_done", i), in_ready[i], 1'b1);
  endtask

  typedef struct {
    int           inst;
    logic [127:0] din;
    logic [127:0] dout;
  } vec_t;

  vec_t vecs [4];

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1);
  end

  initial begin
    logic [127:0] d, got, held, r1, r2;
    int lat, seen, t1, t2, vcount;

    vecs[0] = '{0, 128'h637c777bf26b6fc53001672bfed7ab76, 128'h000102030405060708090a0b0c0d0e0f};
    vecs[1] = '{1, {16{8'h00}}, {16{8'h52}}};
    vecs[2] = '{2, {16{8'h52}}, {16{8'h48}}};
    vecs[3] = '{3, {16{8'h7c}}, {16{8'h01}}};

    in_valid  = '0;
    out_ready = '0;
    in_state  = '0;
    rst_n     = 1'b0;
    build_tables();
    tick();
    tick();
    for (int i = 0; i < 5; i++) begin
      check_bit($sformatf("u%0d_reset_in_ready", i), in_ready[i], 1'b1);
      check_bit($sformatf("u%0d_reset_out_valid", i), out_valid[i], 1'b0);
      check_bit($sformatf("u%0d_reset_busy", i), busy[i], 1'b0);
      check($sformatf("u%0d_reset_out_state", i), out_state[i], 128'h0);
    end
    rst_n = 1'b1;
    tick();

    for (int v = 0; v < 4; v++) begin
      run_block(vecs[v].inst, vecs[v].din, got, lat);
      check($sformatf("vec%0d_result", v), got, vecs[v].dout);
      check($sformatf("vec%0d_latency", v), 128'(lat), 128'(16 >> vecs[v].inst));
    end

    for (int j = 0; j < 16; j++) begin
      for (int k = 0; k < 16; k++) d[127-8*k -: 8] = 8'(j * 16 + k);
      run_block(4, d, got, lat);
      check($sformatf("exh%0d_result", j), got, inv_state(d));
      check($sformatf("exh%0d_sbox_identity", j), fwd_state(got), d);
    end

    d = {$urandom(), $urandom(), $urandom(), $urandom()};
    in_state     = d;
    in_valid[0]  = 1'b1;
    out_ready[0] = 1'b0;
    tick();
    in_valid[0] = 1'b0;
    lat = 0;
    while (!out_valid[0] && lat < 40) begin
      tick();
      lat++;
    end
    check_bit("bp_reach_done", out_valid[0], 1'b1);
    held = out_state[0];
    check("bp_result", held, inv_state(d));
    for (int c = 0; c < 10; c++) begin
      if (c == 4) begin
        in_state    = ~d;
        in_valid[0] = 1'b1;
      end else begin
        in_valid[0] = 1'b0;
      end
      tick();
      check_bit($sformatf("bp%0d_out_valid", c), out_valid[0], 1'b1);
      check($sformatf("bp%0d_out_state", c), out_state[0], inv_state(d));
      check_bit($sformatf("bp%0d_in_ready", c), in_ready[0], 1'b0);
      check_bit($sformatf("bp%0d_busy", c), busy[0], 1'b1);
    end
    in_valid[0]  = 1'b0;
    out_ready[0] = 1'b1;
    tick();
    check_bit("bp_release_out_valid", out_valid[0], 1'b0);
    check_bit("bp_release_in_ready", in_ready[0], 1'b1);
    check_bit("bp_release_busy", busy[0], 1'b0);
    vcount = 0;
    for (int c = 0; c < 20; c++) begin
      tick();
      if (out_valid[0] || busy[0]) vcount++;
    end
    check("bp_pulse_ignored", 128'(vcount), 128'h0);

    in_state     = {16{8'h63}};
    in_valid[2]  = 1'b1;
    out_ready[2] = 1'b1;
    tick();
    in_state = {16{8'h16}};
    seen = 0;
    t1 = -1;
    t2 = -1;
    r1 = '0;
    r2 = '0;
    for (int c = 1; c <= 14 && seen < 2; c++) begin
      tick();
      if (out_valid[2]) begin
        if (seen == 0) begin
          t1 = c;
          r1 = out_state[2];
        end else begin
          t2 = c;
          r2 = out_state[2];
        end
        seen++;
      end
    end
    in_valid[2] = 1'b0;
    check("b2b_first_time", 128'(t1), 128'd4);
    check("b2b_first_data", r1, {16{8'h00}});
    check("b2b_second_time", 128'(t2), 128'd10);
    check("b2b_second_data", r2, {16{8'hff}});
    tick();
    tick();

    d = {$urandom(), $urandom(), $urandom(), $urandom()};
    in_state     = d;
    in_valid[0]  = 1'b1;
    out_ready[0] = 1'b1;
    tick();
    in_valid[0] = 1'b0;
    repeat (5) tick();
    check_bit("rst_mid_busy_before", busy[0], 1'b1);
    rst_n = 1'b0;
    #1;
    check_bit("rst_mid_in_ready", in_ready[0], 1'b1);
    check_bit("rst_mid_out_valid", out_valid[0], 1'b0);
    check_bit("rst_mid_busy", busy[0], 1'b0);
    check("rst_mid_out_state", out_state[0], 128'h0);
    tick();
    rst_n = 1'b1;
    vcount = 0;
    for (int c = 0; c < 20; c++) begin
      tick();
      if (out_valid[0]) vcount++;
    end
    check("rst_no_out_valid", 128'(vcount), 128'h0);
    d = {$urandom(), $urandom(), $urandom(), $urandom()};
    run_block(0, d, got, lat);
    check("rst_fresh_result", got, inv_state(d));
    check("rst_fresh_latency", 128'(lat), 128'd16);

    for (int r = 0; r < 4; r++) begin
      d = {$urandom(), $urandom(), $urandom(), $urandom()};
      for (int i = 0; i < 5; i++) begin
        run_block(i, d, got, lat);
        check($sformatf("sweep%0d_u%0d_result", r, i), got, inv_state(d));
        check($sformatf("sweep%0d_u%0d_latency", r, i), 128'(lat), 128'(16 >> i));
      end
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
